int_responder: RTL



---
 rtl/int_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/int_responder.sv
// int_responder: periodic interrupt source whose events are retired by CPU stores to an acknowledge word.
// Build option INT_RESPONDER_QUEUE_EN: when defined the queue holds MAX_PENDING events, otherwise one.
module int_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7F20,
    parameter int          PERIOD      = 1000,
    parameter int          MAX_PENDING = 7,
    parameter int          GAP         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [7:0]  int_pending,
    output logic [7:0]  int_dropped
);

    localparam int              CW        = $clog2(PERIOD);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [3:0]      GAP_LOAD  = 4'(GAP);
    localparam logic [31:0]     WORD_MASK = 32'hFFFF_FFFC;
`ifdef INT_RESPONDER_QUEUE_EN
    localparam logic [7:0]      LIMIT     = 8'(MAX_PENDING);
`else
    // single-slot queue; MAX_PENDING has no effect in this build
    localparam logic [7:0]      LIMIT     = (MAX_PENDING > 0) ? 8'd1 : 8'd1;
`endif

    logic [CW-1:0] cnt;
    logic [3:0]    gap;
    logic [7:0]    pending;
    logic [7:0]    dropped;
    logic          tick;
    logic          ack;

    assign tick = (cnt == CNT_LAST);
    assign ack  = ((m_int_addr & WORD_MASK) == (BASE_ADDR & WORD_MASK)) && (m_int_byteen != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            gap     <= 4'd0;
            pending <= 8'd0;
            dropped <= 8'd0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (gap != 4'd0) begin
                gap <= gap - 4'd1;
            end
            unique case ({tick, ack})
                2'b10: begin
                    if (pending < LIMIT) begin
                        pending <= pending + 8'd1;
                    end else if (dropped != 8'hFF) begin
                        dropped <= dropped + 8'd1;
                    end
                end
                2'b01: begin
                    // an acknowledge with nothing pending is spurious and ignored
                    if (pending != 8'd0) begin
                        pending <= pending - 8'd1;
                        gap     <= GAP_LOAD;
                    end
                end
                2'b11: begin
                    if (pending != 8'd0) begin
                        gap <= GAP_LOAD;
                    end else begin
                        pending <= 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign interrupt   = (pending != 8'd0) && (gap == 4'd0);
    assign int_pending = pending;
    assign int_dropped = dropped;

endmodule
